ddr2_reset_sequencer: RTL and testbench

Reset and bring-up controller for the DDR2 MCB clocking path, running in the 250 MHz domain. Drives the PLL reset, waits for PLL lock, then releases MCB system reset and waits for calibration done, with timeouts and bounded retries. Monitors lock loss after bring-up and restarts the sequence. Provides a clean user-side reset and ready status to the rest of the FPGA.

---
 rtl/ddr2_reset_pkg.sv | 21 ++
 rtl/ddr2_reset_sequencer_sync_bit.sv | 22 ++
 rtl/ddr2_reset_sequencer.sv | 134 +++++++++++++
 tb/tb_ddr2_reset_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_reset_pkg.sv
// Shared types and constants for the DDR2 MCB reset sequencer.
package ddr2_reset_pkg;

  // Bring-up sequence states.
  typedef enum logic [2:0] {
    PLL_RST    = 3'd0,
    WAIT_LOCK  = 3'd1,
    MCB_RST    = 3'd2,
    WAIT_CALIB = 3'd3,
    READY      = 3'd4,
    FAIL       = 3'd5,
    ERROR      = 3'd6
  } state_t;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  localparam logic [RETRY_W-1:0] RETRY_SAT = {RETRY_W{1'b1}};
  localparam logic [LOSS_W-1:0]  LOSS_SAT  = {LOSS_W{1'b1}};

endpackage

// File: rtl/ddr2_reset_sequencer_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level into the local clock.
module sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives a clean level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ddr2_reset_sequencer.sv
// Reset and bring-up controller for the DDR2 MCB clocking path (250 MHz).
// Sequence: PLL reset -> wait lock -> MCB reset -> wait calib -> READY,
// with timeouts, bounded retries and restart on lock loss.
// Optional build macro DDR2_RESET_STATS_EN: when defined, lock_loss_count and
// retry_count are live; otherwise both outputs are tied to zero (the internal
// retry counter still limits retries).
// Handshake note: restart is a single-cycle level pulse, sampled every cycle;
// there is no ready/ack back to the requester.
module ddr2_reset_sequencer
  import ddr2_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int MCB_RST_CYCLES = 64,
  parameter int CALIB_TIMEOUT  = 4194304,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_WIDTH      = 24
) (
  input  logic       clk_250mhz,
  input  logic       rst_250mhz_n,
  input  logic       mcb_clk_locked,
  input  logic       mcb_calib_done,
  input  logic       restart,
  output logic       pll_rst,
  output logic       mcb_sys_rst,
  output logic       user_rst,
  output logic       ready,
  output logic       error,
  output logic [7:0] lock_loss_count,
  output logic [3:0] retry_count,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_WIDTH-1:0] PLL_LAST   = CNT_WIDTH'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST  = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] MCB_LAST   = CNT_WIDTH'(MCB_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CALIB_LAST = CNT_WIDTH'(CALIB_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0]   RETRY_LIM  = RETRY_W'(MAX_RETRIES);

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] timer;
  logic [RETRY_W-1:0]   retry_cnt;
  logic                 locked_s, calib_s;
  logic                 lock_lost_ready;

  sync_bit u_sync_locked (
    .clk   (clk_250mhz),
    .rst_n (rst_250mhz_n),
    .d     (mcb_clk_locked),
    .q     (locked_s)
  );

  sync_bit u_sync_calib (
    .clk   (clk_250mhz),
    .rst_n (rst_250mhz_n),
    .d     (mcb_calib_done),
    .q     (calib_s)
  );

  assign lock_lost_ready = (state == READY) && !locked_s && !restart;
  assign state_dbg       = state;

  // State register.
  always_ff @(posedge clk_250mhz or negedge rst_250mhz_n) begin
    if (!rst_250mhz_n) state <= PLL_RST;
    else               state <= next_state;
  end

  // Next-state logic; lock loss outranks calib, restart outranks everything.
  always_comb begin
    next_state = state;
    case (state)
      PLL_RST:    if (timer == PLL_LAST) next_state = WAIT_LOCK;
      WAIT_LOCK:  if (locked_s)                next_state = MCB_RST;
                  else if (timer == LOCK_LAST) next_state = FAIL;
      MCB_RST:    if (!locked_s)               next_state = FAIL;
                  else if (timer == MCB_LAST)  next_state = WAIT_CALIB;
      WAIT_CALIB: if (!locked_s)                next_state = FAIL;
                  else if (calib_s)             next_state = READY;
                  else if (timer == CALIB_LAST) next_state = FAIL;
      READY:      if (!locked_s) next_state = PLL_RST;
      FAIL:       if (retry_cnt > RETRY_LIM) next_state = ERROR;
                  else                       next_state = PLL_RST;
      ERROR:      next_state = ERROR;
      default:    next_state = PLL_RST;
    endcase
    if (restart) next_state = PLL_RST;
  end

  // Per-state cycle timer, cleared on every state change and on restart.
  always_ff @(posedge clk_250mhz or negedge rst_250mhz_n) begin
    if (!rst_250mhz_n)                        timer <= '0;
    else if (restart || next_state != state)  timer <= '0;
    else                                      timer <= timer + 1'b1;
  end

  // Failed-attempt counter: bumped on entry to FAIL, so FAIL sees the new value.
  always_ff @(posedge clk_250mhz or negedge rst_250mhz_n) begin
    if (!rst_250mhz_n)                                   retry_cnt <= '0;
    else if (restart || lock_lost_ready)                 retry_cnt <= '0;
    else if (next_state == FAIL && retry_cnt != RETRY_SAT) retry_cnt <= retry_cnt + 1'b1;
  end

  // Registered outputs decoded from the next state so they align with state.
  always_ff @(posedge clk_250mhz or negedge rst_250mhz_n) begin
    if (!rst_250mhz_n) begin
      pll_rst     <= 1'b1;
      mcb_sys_rst <= 1'b1;
      user_rst    <= 1'b1;
      ready       <= 1'b0;
      error       <= 1'b0;
    end else begin
      pll_rst     <= (next_state == PLL_RST) || (next_state == ERROR);
      mcb_sys_rst <= !((next_state == WAIT_CALIB) || (next_state == READY));
      user_rst    <= (next_state != READY);
      ready       <= (next_state == READY);
      error       <= (next_state == ERROR);
    end
  end

`ifdef DDR2_RESET_STATS_EN
  // Saturating count of lock losses observed while READY.
  always_ff @(posedge clk_250mhz or negedge rst_250mhz_n) begin
    if (!rst_250mhz_n)                                lock_loss_count <= '0;
    else if (lock_lost_ready && lock_loss_count != LOSS_SAT) lock_loss_count <= lock_loss_count + 1'b1;
  end

  assign retry_count = retry_cnt;
`else
  assign lock_loss_count = '0;
  assign retry_count     = '0;
`endif

endmodule

// File: tb/tb_ddr2_reset_sequencer.sv
// Directed bench for ddr2_reset_sequencer with shortened timeouts.
// Vectors are {input levels, cycles to advance, expected outputs}; multi-cycle
// corners (lock loss, timeout retries, restart, async reset) are hand-written.
module tb_ddr2_reset_sequencer;

  localparam int PLL_C    = 16;
  localparam int LOCK_TO  = 256;
  localparam int MCB_C    = 64;
  localparam int CALIB_TO = 1024;
  localparam int MAXR     = 3;
  localparam int ATTEMPT  = PLL_C + LOCK_TO + 1;

`ifdef DDR2_RESET_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked, calib, restart;
  logic       pll_rst, mcb_sys_rst, user_rst, ready, error;
  logic [7:0] lock_loss_count;
  logic [3:0] retry_count;
  logic [2:0] state_dbg;

  always #2 clk = ~clk;

  ddr2_reset_sequencer #(
    .PLL_RST_CYCLES (PLL_C),
    .LOCK_TIMEOUT   (LOCK_TO),
    .MCB_RST_CYCLES (MCB_C),
    .CALIB_TIMEOUT  (CALIB_TO),
    .MAX_RETRIES    (MAXR),
    .CNT_WIDTH      (24)
  ) dut (
    .clk_250mhz      (clk),
    .rst_250mhz_n    (rst_n),
    .mcb_clk_locked  (locked),
    .mcb_calib_done  (calib),
    .restart         (restart),
    .pll_rst         (pll_rst),
    .mcb_sys_rst     (mcb_sys_rst),
    .user_rst        (user_rst),
    .ready           (ready),
    .error           (error),
    .lock_loss_count (lock_loss_count),
    .retry_count     (retry_count),
    .state_dbg       (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  typedef struct {
    int          adv;
    logic        locked;
    logic        calib;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [16:0] pk(logic p, logic m, logic u, logic r, logic e,
                                     int loss, int retry);
    logic [7:0] l;
    logic [3:0] rt;
    l  = STATS ? 8'(loss)  : 8'd0;
    rt = STATS ? 4'(retry) : 4'd0;
    return {p, m, u, r, e, l, rt};
  endfunction

  function automatic logic [16:0] outs();
    return {pll_rst, mcb_sys_rst, user_rst, ready, error, lock_loss_count, retry_count};
  endfunction

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {pll,mcb,user,rdy,err,loss,retry}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ready_hits;
    int err_at;
    int prev;
    int fall_t[$];

    rst_n   = 1'b0;
    locked  = 1'b0;
    calib   = 1'b0;
    restart = 1'b0;
    adv(3);
    check("reset_values", pk(1, 1, 1, 0, 0, 0, 0));
    check_int("reset_state_dbg", int'(state_dbg), 0);
    rst_n = 1'b1;

    // Nominal bring-up: lock 100 cycles after pll_rst falls, calib 500 after mcb_sys_rst falls.
    vecs[0] = '{15,  1'b0, 1'b0, pk(1, 1, 1, 0, 0, 0, 0), "pll_rst_held"};
    vecs[1] = '{1,   1'b0, 1'b0, pk(0, 1, 1, 0, 0, 0, 0), "pll_rst_released"};
    vecs[2] = '{100, 1'b0, 1'b0, pk(0, 1, 1, 0, 0, 0, 0), "wait_lock"};
    vecs[3] = '{2,   1'b1, 1'b0, pk(0, 1, 1, 0, 0, 0, 0), "lock_sync_lag"};
    vecs[4] = '{64,  1'b1, 1'b0, pk(0, 1, 1, 0, 0, 0, 0), "mcb_rst_held"};
    vecs[5] = '{1,   1'b1, 1'b0, pk(0, 0, 1, 0, 0, 0, 0), "mcb_rst_released"};
    vecs[6] = '{500, 1'b1, 1'b0, pk(0, 0, 1, 0, 0, 0, 0), "wait_calib"};
    vecs[7] = '{2,   1'b1, 1'b1, pk(0, 0, 1, 0, 0, 0, 0), "calib_sync_lag"};
    vecs[8] = '{1,   1'b1, 1'b1, pk(0, 0, 0, 1, 0, 0, 0), "ready_asserted"};
    vecs[9] = '{50,  1'b1, 1'b1, pk(0, 0, 0, 1, 0, 0, 0), "ready_stable"};
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp);

    foreach (vecs[i]) begin
      locked = vecs[i].locked;
      calib  = vecs[i].calib;
      adv(vecs[i].adv);
      check(vecs[i].name, exp_q.pop_front());
    end

    // Lock loss in READY for 10 cycles; ready drops 3 cycles after the pin.
    locked = 1'b0;
    adv(2);
    check("loss_ready_hold", pk(0, 0, 0, 1, 0, 0, 0));
    adv(1);
    check("loss_ready_drop", pk(1, 1, 1, 0, 0, 1, 0));
    adv(7);
    locked = 1'b1;
    adv(74);
    check("loss_not_yet_ready", pk(0, 0, 1, 0, 0, 1, 0));
    adv(1);
    check("loss_ready_again", pk(0, 0, 0, 1, 0, 1, 0));

    // 299 further losses: count saturates at 255.
    for (int k = 0; k < 299; k++) begin
      locked = 1'b0;
      adv(10);
      locked = 1'b1;
      adv(75);
    end
    check("loss_saturate", pk(0, 0, 0, 1, 0, 255, 0));

    // Restart from READY.
    restart = 1'b1;
    calib   = 1'b0;
    adv(1);
    restart = 1'b0;
    check("restart_in_ready", pk(1, 1, 1, 0, 0, 255, 0));
    adv(81);
    check("reach_wait_calib", pk(0, 0, 1, 0, 0, 255, 0));

    // Lock loss and calib rise on the same cycle in WAIT_CALIB.
    adv(8);
    locked     = 1'b0;
    calib      = 1'b1;
    ready_hits = 0;
    for (int k = 0; k < 2; k++) begin
      adv(1);
      if (ready) ready_hits++;
    end
    adv(1);
    if (ready) ready_hits++;
    check("fail_state", pk(0, 1, 1, 0, 0, 255, 1));
    adv(1);
    if (ready) ready_hits++;
    check("fail_to_pll_rst", pk(1, 1, 1, 0, 0, 255, 1));
    check_int("no_ready_pulse", ready_hits, 0);

    // Lock never arrives: four attempts ATTEMPT cycles apart, then ERROR.
    calib = 1'b0;
    adv(6);
    restart = 1'b1;
    adv(1);
    restart = 1'b0;
    check("restart_clears_retry", pk(1, 1, 1, 0, 0, 255, 0));
    err_at = -1;
    prev   = 1;
    for (int i = 1; i <= 1200 && err_at < 0; i++) begin
      adv(1);
      if (prev == 1 && !pll_rst) fall_t.push_back(i);
      if (error) err_at = i;
      prev = int'(pll_rst);
    end
    check_int("timeout_pulse_count", fall_t.size(), MAXR + 1);
    foreach (fall_t[k]) check_int($sformatf("timeout_pulse_%0d_fall", k), fall_t[k], PLL_C + k * ATTEMPT);
    check_int("timeout_error_cycle", err_at, (MAXR + 1) * ATTEMPT);
    check("error_state", pk(1, 1, 1, 0, 1, 255, 4));
    adv(5);
    check("error_holds", pk(1, 1, 1, 0, 1, 255, 4));

    // Restart from ERROR, then bring up to WAIT_CALIB and hit async reset.
    restart = 1'b1;
    locked  = 1'b1;
    adv(1);
    restart = 1'b0;
    check("restart_in_error", pk(1, 1, 1, 0, 0, 255, 0));
    adv(100);
    check("pre_async_wait_calib", pk(0, 0, 1, 0, 0, 255, 0));
    rst_n = 1'b0;
    #1;
    check("async_reset_values", pk(1, 1, 1, 0, 0, 0, 0));
    adv(3);
    rst_n = 1'b1;
    adv(15);
    check("post_reset_pll_held", pk(1, 1, 1, 0, 0, 0, 0));
    adv(1);
    check("post_reset_wait_lock", pk(0, 1, 1, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
